// File: rtl/ofdm_pkg.sv
// Shared definitions for the OFDM frame sequencer: state encoding, default
// frame geometry and the sample payload handed to the output register.
package ofdm_pkg;

   localparam int unsigned PRE_LEN_DEF = 320;
   localparam int unsigned SYM_LEN_DEF = 80;
   localparam int unsigned GAP_LEN_DEF = 16;
   localparam int unsigned SAMPLE_W    = 16;
   localparam int unsigned NSYM_W      = 8;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PREAMBLE = 2'd1,
      ST_DATA     = 2'd2,
      ST_GAP      = 2'd3
   } ofdm_state_e;

   typedef struct packed {
      logic [SAMPLE_W-1:0] data;
      logic                sop;
      logic                eop;
   } ofdm_sample_t;

   // Counter width able to index 0..n-1, never narrower than one bit
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/ofdm_out_reg.sv
// Output sample register with valid/ready hold: loads whenever it is empty or
// the downstream consumer takes the current sample, otherwise freezes.
module ofdm_out_reg
   import ofdm_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   input  logic                i_ready,
   input  logic                i_fire,
   input  ofdm_sample_t        i_sample,
   output logic                o_load_c,
   output logic [SAMPLE_W-1:0] o_data,
   output logic                o_valid,
   output logic                o_sop,
   output logic                o_eop
);

   // Register may be overwritten when empty or when its content is consumed
   assign o_load_c = !o_valid || i_ready;

   // Capture a new sample, or a bubble when nothing fires, on every load
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         o_data  <= '0;
         o_valid <= 1'b0;
         o_sop   <= 1'b0;
         o_eop   <= 1'b0;
      end else if (o_load_c) begin
         o_valid <= i_fire;
         o_data  <= i_fire ? i_sample.data : '0;
         o_sop   <= i_fire && i_sample.sop;
         o_eop   <= i_fire && i_sample.eop;
      end
   end

endmodule

// File: rtl/ofdm_frame_sequencer.sv
// OFDM frame sequencer: on request emits one frame made of a preamble, n_sym
// data symbols and a zero gap, muxing two upstream streams into a single
// registered output with valid/ready flow control.
module ofdm_frame_sequencer
   import ofdm_pkg::*;
#(
   parameter int unsigned PRE_LEN = PRE_LEN_DEF,
   parameter int unsigned SYM_LEN = SYM_LEN_DEF,
   parameter int unsigned GAP_LEN = GAP_LEN_DEF
)(
   input  logic               clock,
   input  logic               reset,
   input  logic               enable,
   input  logic [7:0]         n_sym,
   input  logic signed [15:0] pre_data,
   input  logic               pre_valid,
   output logic               pre_ready,
   input  logic signed [15:0] dat_data,
   input  logic               dat_valid,
   output logic               dat_ready,
   input  logic               ready_in,
   output logic signed [15:0] out_i,
   output logic               out_valid,
   output logic               sop,
   output logic               eop,
   output logic               busy
);

   localparam int unsigned SAMP_W = max3(cnt_w(PRE_LEN), cnt_w(SYM_LEN), cnt_w(GAP_LEN));

   ofdm_state_e         r_state;
   logic [SAMP_W-1:0]   r_samp_cnt;
   logic [NSYM_W-1:0]   r_sym_cnt;
   logic [NSYM_W-1:0]   r_nsym;
   logic                r_busy;

   logic                w_load;
   logic                w_pre_fire;
   logic                w_dat_fire;
   logic                w_gap_fire;
   logic                w_fire;
   logic                w_pre_last;
   logic                w_sym_end;
   logic                w_last_sym;
   logic                w_gap_last;
   ofdm_sample_t        w_sample;
   logic [SAMPLE_W-1:0] w_out_data;

   // Upstream handshakes happen only when the output register can take the sample
   assign pre_ready  = (r_state == ST_PREAMBLE) && w_load;
   assign dat_ready  = (r_state == ST_DATA) && w_load;
   assign w_pre_fire = pre_ready && pre_valid;
   assign w_dat_fire = dat_ready && dat_valid;
   assign w_gap_fire = (r_state == ST_GAP) && w_load;
   assign w_fire     = w_pre_fire || w_dat_fire || w_gap_fire;

   // Position decodes used for phase transitions and frame markers
   assign w_pre_last = (r_samp_cnt == SAMP_W'(PRE_LEN - 1));
   assign w_sym_end  = (r_samp_cnt == SAMP_W'(SYM_LEN - 1));
   assign w_gap_last = (r_samp_cnt == SAMP_W'(GAP_LEN - 1));
   assign w_last_sym = ((r_sym_cnt + NSYM_W'(1)) == r_nsym);

   // Select the sample presented to the output register and tag frame edges
   always_comb begin
      w_sample = '0;
      case (r_state)
         ST_PREAMBLE: begin
            w_sample.data = pre_data;
            w_sample.sop  = (r_samp_cnt == '0);
            w_sample.eop  = w_pre_last && (r_nsym == '0);
         end
         ST_DATA: begin
            w_sample.data = dat_data;
            w_sample.eop  = w_sym_end && w_last_sym;
         end
         default: w_sample = '0;
      endcase
   end

   // Frame FSM with sample/symbol counters; counters advance only on accepted samples
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_samp_cnt <= '0;
         r_sym_cnt  <= '0;
         r_nsym     <= '0;
         r_busy     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (enable) begin
                  r_state    <= ST_PREAMBLE;
                  r_nsym     <= n_sym;
                  r_samp_cnt <= '0;
                  r_sym_cnt  <= '0;
                  r_busy     <= 1'b1;
               end
            end
            ST_PREAMBLE: begin
               if (w_pre_fire) begin
                  if (w_pre_last) begin
                     r_samp_cnt <= '0;
                     r_state    <= (r_nsym == '0) ? ST_GAP : ST_DATA;
                  end else begin
                     r_samp_cnt <= r_samp_cnt + SAMP_W'(1);
                  end
               end
            end
            ST_DATA: begin
               if (w_dat_fire) begin
                  if (w_sym_end) begin
                     r_samp_cnt <= '0;
                     r_sym_cnt  <= r_sym_cnt + NSYM_W'(1);
                     if (w_last_sym) begin
                        r_state <= ST_GAP;
                     end
                  end else begin
                     r_samp_cnt <= r_samp_cnt + SAMP_W'(1);
                  end
               end
            end
            ST_GAP: begin
               if (w_gap_fire) begin
                  if (w_gap_last) begin
                     r_samp_cnt <= '0;
                     // A pending request chains the next frame with no idle cycle
                     if (enable) begin
                        r_state   <= ST_PREAMBLE;
                        r_nsym    <= n_sym;
                        r_sym_cnt <= '0;
                     end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                     end
                  end else begin
                     r_samp_cnt <= r_samp_cnt + SAMP_W'(1);
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Output register with 1-cycle latency and stall hold
   ofdm_out_reg u_out_reg (
      .clock    (clock),
      .reset    (reset),
      .i_ready  (ready_in),
      .i_fire   (w_fire),
      .i_sample (w_sample),
      .o_load_c (w_load),
      .o_data   (w_out_data),
      .o_valid  (out_valid),
      .o_sop    (sop),
      .o_eop    (eop)
   );

   assign out_i = w_out_data;
   assign busy  = r_busy;

endmodule

// File: tb/tb_ofdm_frame_sequencer.sv
// Bench for ofdm_frame_sequencer: drives golden preamble/data sources and a
// downstream consumer, compares the consumed stream with a frame model.
module tb_ofdm_frame_sequencer;

   localparam int PRE_LEN = 320;
   localparam int SYM_LEN = 80;
   localparam int GAP_LEN = 16;

   logic               clock = 1'b0;
   logic               reset;
   logic               enable;
   logic [7:0]         n_sym;
   logic signed [15:0] pre_data;
   logic               pre_valid;
   logic               pre_ready;
   logic signed [15:0] dat_data;
   logic               dat_valid;
   logic               dat_ready;
   logic               ready_in;
   logic signed [15:0] out_i;
   logic               out_valid;
   logic               sop;
   logic               eop;
   logic               busy;

   int errors = 0;
   int checks = 0;
   int dsrc   = 0;

   always #5 clock = ~clock;

   ofdm_frame_sequencer #(
      .PRE_LEN (PRE_LEN),
      .SYM_LEN (SYM_LEN),
      .GAP_LEN (GAP_LEN)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .enable    (enable),
      .n_sym     (n_sym),
      .pre_data  (pre_data),
      .pre_valid (pre_valid),
      .pre_ready (pre_ready),
      .dat_data  (dat_data),
      .dat_valid (dat_valid),
      .dat_ready (dat_ready),
      .ready_in  (ready_in),
      .out_i     (out_i),
      .out_valid (out_valid),
      .sop       (sop),
      .eop       (eop),
      .busy      (busy)
   );

   typedef struct {
      logic [15:0] d;
      bit          s;
      bit          e;
   } exp_t;

   // One frame scenario: stimulus knobs plus expected frame-level results (-1 = don't care)
   typedef struct {
      int n;
      int nfr;
      int pv;
      int dv;
      int rdy;
      int stall;
      int tot;
      int eopi;
      int sopn;
      int bub;
      int gap;
      bit dr;
   } vec_t;

   exp_t exp_q[$];

   function automatic logic [15:0] gp(input int k);
      return 16'(k * 37 + 5) ^ 16'h5A00;
   endfunction

   function automatic logic [15:0] gd(input int k);
      return 16'(k * 113 + 4660) ^ 16'h00C3;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Build the expected stream from the frame rules, then act as source and sink
   task automatic run(input vec_t v);
      int   flen, total, got, pi, dbase, stall_left, bub, sopn, eopi, c_last, c_sop2;
      bit   stall_done, hold, dr_seen, done;
      logic [18:0] prev_o;
      exp_t e;
      flen  = PRE_LEN + SYM_LEN * v.n + GAP_LEN;
      total = v.nfr * flen;
      dbase = dsrc;
      exp_q.delete();
      for (int f = 0; f < v.nfr; f++) begin
         for (int k = 0; k < PRE_LEN; k++) begin
            e.d = gp(k); e.s = (k == 0); e.e = (v.n == 0) && (k == PRE_LEN - 1);
            exp_q.push_back(e);
         end
         for (int j = 0; j < SYM_LEN * v.n; j++) begin
            e.d = gd(dbase + j); e.s = 1'b0; e.e = (j == SYM_LEN * v.n - 1);
            exp_q.push_back(e);
         end
         dbase += SYM_LEN * v.n;
         for (int g = 0; g < GAP_LEN; g++) begin
            e.d = 16'h0; e.s = 1'b0; e.e = 1'b0;
            exp_q.push_back(e);
         end
      end
      dbase = dsrc;
      got = 0; pi = 0; eopi = -1; sopn = 0; bub = 0; c_last = -1; c_sop2 = -1;
      stall_left = 0; stall_done = 0; hold = 0; dr_seen = 0; done = 0; prev_o = '0;
      n_sym = 8'(v.n);
      for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
         if (hold) chk("hold", {out_i, out_valid, sop, eop}, prev_o);
         if (!stall_done && v.stall == 1 && got == 100) begin stall_left = 5; stall_done = 1; end
         if (!stall_done && v.stall == 2 && dsrc - dbase == 40) begin stall_left = 3; stall_done = 1; end
         ready_in  = (v.stall == 1 && stall_left > 0) ? 1'b0 : ($urandom_range(99) < v.rdy);
         pre_valid = ($urandom_range(99) < v.pv);
         dat_valid = (v.stall == 2 && stall_left > 0) ? 1'b0 : ($urandom_range(99) < v.dv);
         if (stall_left > 0) stall_left--;
         pre_data = gp(pi % PRE_LEN);
         dat_data = gd(dsrc);
         enable   = (v.nfr > 1) ? (got <= flen) : (cyc == 0);
         if (v.nfr == 1 && cyc > 0) n_sym = 8'($urandom);
         if (out_valid && got <= total - 2) chk("busy_mid", busy, 1);
         if (got > 0 && !out_valid) bub++;
         if (out_valid && ready_in) begin
            e = exp_q.pop_front();
            chk("sample", {out_i, sop, eop}, {e.d, e.s, e.e});
            if (sop) sopn++;
            if (eop && eopi < 0) eopi = got;
            if (got == flen - 1) c_last = cyc;
            if (got == flen) c_sop2 = cyc;
            if (got == total - 1) begin
               chk("busy_end", busy, 0);
               done = 1;
            end
            got++;
         end
         hold   = out_valid && !ready_in;
         prev_o = {out_i, out_valid, sop, eop};
         #1;
         if (hold) chk("ready_gate", {pre_ready, dat_ready}, 2'b00);
         if (dat_ready) dr_seen = 1;
         if (pre_valid && pre_ready) pi++;
         if (dat_valid && dat_ready) dsrc++;
         @(posedge clock); #1;
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL timeout: got %0d of %0d samples", got, total);
      end
      chk("count", got, v.tot);
      chk("eop_idx", eopi, v.eopi);
      chk("sop_cnt", sopn, v.sopn);
      chk("dat_ready_seen", dr_seen, v.dr);
      if (v.bub >= 0) chk("bubbles", bub, v.bub);
      if (v.gap >= 0) chk("gap_to_sop", c_sop2 - c_last, v.gap);
      enable = 0; pre_valid = 0; dat_valid = 0; ready_in = 1;
      @(posedge clock); #1;
      chk("idle_after", {out_valid, busy}, 2'b00);
   endtask

   vec_t vecs[8];
   vec_t vr;
   int   got, pi, rn;
   bit   hit;

   initial begin
      vecs[0] = '{2, 1, 100, 100, 100, 0, 496, 479, 1,  0, -1, 1'b1};
      vecs[1] = '{0, 1, 100, 100, 100, 0, 336, 319, 1,  0, -1, 1'b0};
      vecs[2] = '{1, 1, 100, 100, 100, 1, 416, 399, 1,  0, -1, 1'b1};
      vecs[3] = '{2, 1, 100, 100, 100, 2, 496, 479, 1,  3, -1, 1'b1};
      vecs[4] = '{1, 2, 100, 100, 100, 0, 832, 399, 2,  0,  1, 1'b1};
      vecs[5] = '{3, 1,  60,  70,  75, 0, 576, 559, 1, -1, -1, 1'b1};
      vecs[6] = '{0, 1,  50,  50,  50, 0, 336, 319, 1, -1, -1, 1'b0};
      vecs[7] = '{1, 2,  80,  80,  60, 0, 832, 399, 2, -1, -1, 1'b1};

      reset = 1; enable = 0; n_sym = 0; pre_data = 0; pre_valid = 0;
      dat_data = 0; dat_valid = 0; ready_in = 0;
      repeat (3) @(posedge clock);
      #1;
      chk("reset_state", {out_i, out_valid, sop, eop, busy, pre_ready, dat_ready}, '0);
      @(negedge clock); reset = 0;
      ready_in = 1; pre_valid = 1; dat_valid = 1;
      repeat (4) begin
         @(posedge clock); #1;
         chk("wait_enable", {out_valid, busy}, 2'b00);
      end
      pre_valid = 0; dat_valid = 0;

      foreach (vecs[i]) run(vecs[i]);

      // Mid-preamble reset, then a clean frame must restart from preamble index 0
      n_sym = 1; pre_valid = 1; dat_valid = 1; ready_in = 1;
      got = 0; pi = 0; hit = 0;
      for (int cyc = 0; cyc < 400 && !hit; cyc++) begin
         enable = (cyc == 0);
         if (out_valid) begin
            if (got == 100) hit = 1;
            else got++;
         end
         if (!hit) begin
            pre_data = gp(pi);
            #1;
            if (pre_valid && pre_ready) pi++;
            @(posedge clock); #1;
         end
      end
      chk("pre_sample_100", {hit, out_i}, {1'b1, gp(100)});
      #2 reset = 1;
      #1 chk("reset_async", {out_i, out_valid, sop, eop, busy, pre_ready, dat_ready}, '0);
      @(posedge clock); #1;
      chk("reset_edge", {out_i, out_valid, sop, eop, busy, pre_ready, dat_ready}, '0);
      @(negedge clock); reset = 0;
      @(posedge clock); #1;
      chk("post_reset_idle", {out_valid, busy}, 2'b00);
      pre_valid = 0; dat_valid = 0;
      vr = '{1, 1, 100, 100, 100, 0, 416, 399, 1, 0, -1, 1'b1};
      run(vr);

      // Random frames with expectations derived from the frame geometry
      for (int r = 0; r < 4; r++) begin
         rn     = int'($urandom_range(3));
         vr.n   = rn;
         vr.nfr = 1;
         vr.pv  = int'($urandom_range(90, 40));
         vr.dv  = int'($urandom_range(90, 40));
         vr.rdy = int'($urandom_range(90, 40));
         vr.stall = 0;
         vr.tot  = PRE_LEN + SYM_LEN * rn + GAP_LEN;
         vr.eopi = (rn == 0) ? PRE_LEN - 1 : PRE_LEN + SYM_LEN * rn - 1;
         vr.sopn = 1;
         vr.bub  = -1;
         vr.gap  = -1;
         vr.dr   = (rn != 0);
         run(vr);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
